// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle 16-bit-instruction core:
// opcodes, FSM states and instruction field positions.
package cpu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_SLT  = 4'h5;
   localparam logic [3:0] OP_ADDI = 4'h6;
   localparam logic [3:0] OP_LW   = 4'h7;
   localparam logic [3:0] OP_SW   = 4'h8;
   localparam logic [3:0] OP_BEQ  = 4'h9;
   localparam logic [3:0] OP_J    = 4'hA;
   localparam logic [3:0] OP_BL   = 4'hB;
   localparam logic [3:0] OP_BR   = 4'hC;
   localparam logic [3:0] OP_SHL  = 4'hD;
   localparam logic [3:0] OP_NOP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 12;
   localparam int RS_MSB   = 11;
   localparam int RS_LSB   = 8;
   localparam int RT_MSB   = 7;
   localparam int RT_LSB   = 4;
   localparam int RD_MSB   = 3;
   localparam int RD_LSB   = 0;
   localparam int IMM8_MSB = 11;
   localparam int IMM8_LSB = 4;
   localparam int TGT_MSB  = 11;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

endpackage

// File: rtl/cpu_regfile.sv
// 16-entry register file: two asynchronous read ports, one synchronous
// write port, r0 reads as zero and ignores writes.
module cpu_regfile
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [3:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        raddr_a,
   input  logic [3:0]        raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs_r [16];

   // Register storage: cleared on reset, r0 never written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            regs_r[i] <= '0;
         end
      end else if (we && (waddr != 4'd0)) begin
         regs_r[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == 4'd0) ? '0 : regs_r[raddr_a];
   assign rdata_b = (raddr_b == 4'd0) ? '0 : regs_r[raddr_b];

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle core: FETCH/DECODE/EXEC/MEM/WB sequencing over a single
// req/ack memory port. All memory-side and status outputs are registered.
module cpu_multicycle
   import cpu_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                LINK_REG = 15
)(
   input  logic              clk,
   input  logic              pc_reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              halted,
   output logic              retire,
   output logic [ADDR_W-1:0] dbg_pc
);

   localparam logic [ADDR_W-1:0] J_MASK = {ADDR_W{1'b1}} << 12;

   state_t            state_r, state_s;
   logic [15:0]       ir_r;
   logic [ADDR_W-1:0] pc_r, pc_inc_s, npc_s, br_off_s, bl_off_s, addr_s, mem_addr_r;
   logic [DATA_W-1:0] a_r, b_r, res_r, rf_a_s, rf_b_s, alu_s, imm4_s, ea_s;
   logic [DATA_W-1:0] wdata_s, mem_wdata_r;
   logic [3:0]        op_s, rs_s, rt_s, rd_s, rf_waddr_s;
   logic              xfer_s, rf_we_s, pc_ld_s;
   logic              req_s, we_s, retire_s, halted_s;
   logic              mem_req_r, mem_we_r, retire_r, halted_r;

   assign op_s     = ir_r[OP_MSB:OP_LSB];
   assign rs_s     = ir_r[RS_MSB:RS_LSB];
   assign rt_s     = ir_r[RT_MSB:RT_LSB];
   assign rd_s     = ir_r[RD_MSB:RD_LSB];
   assign imm4_s   = {{(DATA_W-4){ir_r[RD_MSB]}}, ir_r[RD_MSB:RD_LSB]};
   assign br_off_s = {{(ADDR_W-4){ir_r[RD_MSB]}}, ir_r[RD_MSB:RD_LSB]};
   assign bl_off_s = {{(ADDR_W-8){ir_r[IMM8_MSB]}}, ir_r[IMM8_MSB:IMM8_LSB]};
   assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign ea_s     = a_r + imm4_s;
   // A transfer only counts while our own request is up
   assign xfer_s   = mem_req_r && mem_ack;

   cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
      .clk     (clk),
      .rst     (pc_reset),
      .we      (rf_we_s),
      .waddr   (rf_waddr_s),
      .wdata   (res_r),
      .raddr_a (rs_s),
      .raddr_b (rt_s),
      .rdata_a (rf_a_s),
      .rdata_b (rf_b_s)
   );

   // ALU: result for R-type, ADDI and the BL link value
   always_comb begin
      alu_s = '0;
      case (op_s)
         OP_ADD:  alu_s = a_r + b_r;
         OP_SUB:  alu_s = a_r - b_r;
         OP_AND:  alu_s = a_r & b_r;
         OP_OR:   alu_s = a_r | b_r;
         OP_XOR:  alu_s = a_r ^ b_r;
         OP_SLT:  alu_s = ($signed(a_r) < $signed(b_r)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
         OP_ADDI: alu_s = ea_s;
         OP_BL:   alu_s = DATA_W'(pc_inc_s);
         OP_SHL:  alu_s = a_r << b_r[3:0];
         default: alu_s = '0;
      endcase
   end

   // Next PC for the instruction currently held in IR
   always_comb begin
      npc_s = pc_inc_s;
      case (op_s)
         OP_BEQ:  npc_s = (a_r == b_r) ? (pc_inc_s + br_off_s) : pc_inc_s;
         OP_J:    npc_s = (pc_inc_s & J_MASK) | ADDR_W'(ir_r[TGT_MSB:0]);
         OP_BL:   npc_s = pc_inc_s + bl_off_s;
         OP_BR:   npc_s = ADDR_W'(a_r);
         default: npc_s = pc_inc_s;
      endcase
   end

   // Writeback destination, only active in WB
   always_comb begin
      rf_we_s    = 1'b0;
      rf_waddr_s = rd_s;
      if (state_r == WB) begin
         case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SHL: begin
               rf_we_s    = 1'b1;
               rf_waddr_s = rd_s;
            end
            OP_ADDI, OP_LW: begin
               rf_we_s    = 1'b1;
               rf_waddr_s = rt_s;
            end
            OP_BL: begin
               rf_we_s    = 1'b1;
               rf_waddr_s = LINK_REG[3:0];
            end
            default: rf_we_s = 1'b0;
         endcase
      end else begin
         rf_we_s = 1'b0;
      end
   end

   // FSM next state and next values of the registered outputs
   always_comb begin
      state_s  = state_r;
      req_s    = mem_req_r;
      we_s     = mem_we_r;
      addr_s   = mem_addr_r;
      wdata_s  = mem_wdata_r;
      retire_s = 1'b0;
      halted_s = halted_r;
      pc_ld_s  = 1'b0;
      case (state_r)
         FETCH: begin
            req_s  = 1'b1;
            we_s   = 1'b0;
            addr_s = pc_r;
            if (xfer_s) begin
               state_s = DECODE;
               req_s   = 1'b0;
            end else begin
               state_s = FETCH;
            end
         end
         DECODE: state_s = EXEC;
         EXEC: begin
            case (op_s)
               OP_LW, OP_SW: begin
                  state_s = MEM;
                  req_s   = 1'b1;
                  we_s    = (op_s == OP_SW);
                  addr_s  = ADDR_W'(ea_s);
                  wdata_s = b_r;
               end
               OP_HALT: begin
                  state_s  = HALT;
                  req_s    = 1'b0;
                  retire_s = 1'b1;
                  halted_s = 1'b1;
               end
               OP_BEQ, OP_J, OP_BR, OP_NOP: begin
                  state_s  = FETCH;
                  req_s    = 1'b1;
                  we_s     = 1'b0;
                  addr_s   = npc_s;
                  pc_ld_s  = 1'b1;
                  retire_s = 1'b1;
               end
               default: state_s = WB;
            endcase
         end
         MEM: begin
            if (xfer_s && (op_s == OP_SW)) begin
               state_s  = FETCH;
               req_s    = 1'b1;
               we_s     = 1'b0;
               addr_s   = npc_s;
               pc_ld_s  = 1'b1;
               retire_s = 1'b1;
            end else if (xfer_s) begin
               state_s = WB;
               req_s   = 1'b0;
               we_s    = 1'b0;
            end else begin
               state_s = MEM;
            end
         end
         WB: begin
            state_s  = FETCH;
            req_s    = 1'b1;
            we_s     = 1'b0;
            addr_s   = npc_s;
            pc_ld_s  = 1'b1;
            retire_s = 1'b1;
         end
         HALT: begin
            state_s = HALT;
            req_s   = 1'b0;
            we_s    = 1'b0;
         end
         default: begin
            state_s = FETCH;
            req_s   = 1'b0;
            we_s    = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) begin
         state_r     <= FETCH;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         retire_r    <= 1'b0;
         halted_r    <= 1'b0;
      end else begin
         state_r     <= state_s;
         mem_req_r   <= req_s;
         mem_we_r    <= we_s;
         mem_addr_r  <= addr_s;
         mem_wdata_r <= wdata_s;
         retire_r    <= retire_s;
         halted_r    <= halted_s;
      end
   end

   // Datapath registers: IR, operands, result/load data, PC
   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) begin
         ir_r  <= 16'h0000;
         a_r   <= '0;
         b_r   <= '0;
         res_r <= '0;
         pc_r  <= RESET_PC;
      end else begin
         if ((state_r == FETCH) && xfer_s) begin
            ir_r <= mem_rdata[15:0];
         end
         if (state_r == DECODE) begin
            a_r <= rf_a_s;
            b_r <= rf_b_s;
         end
         if (state_r == EXEC) begin
            res_r <= alu_s;
         end else if ((state_r == MEM) && xfer_s && (op_s == OP_LW)) begin
            res_r <= mem_rdata;
         end
         if (pc_ld_s) begin
            pc_r <= npc_s;
         end
      end
   end

   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign retire    = retire_r;
   assign halted    = halted_r;
   assign dbg_pc    = pc_r;

endmodule
